ptmch_cmd_cap: RTL and testbench
================================

# ptmch_cmd_cap

SPI_CLK-domain command capture stage on the snooped SPI-NAND bus. It deserialises each CS frame's opcode and address bytes and classifies the opcode. For recognised commands it publishes opcode, kind and address with a toggle strobe. The strobe is consumed downstream in the CLK200M domain by the pattern-match/trigger stage, which needs page-address-qualified triggers instead of opcode-only matching.

## Interface
- P_ADDR_W, 24: width of published address
- P_CNT_W, 8: width of published command counter
- SPI_CLK  in  1  snooped SPI clock, mode 0; sample MOSI on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- SPI_CS  in  1  snooped chip select, active-low; high = idle, also asynchronous frame clear
- SPI_MOSI  in  1  snooped MOSI, MSB first
- CMD_OPCODE  out  8  opcode of last published command
- CMD_KIND  out  2  0 none, 1 ROW (3 addr bytes), 2 COL (2 addr bytes)
- CMD_ADDR  out  P_ADDR_W  address of last published command, right-justified, zero-extended
- CMD_TGL  out  1  toggles once per published command
- CMD_CNT  out  P_CNT_W  published command count, wraps

## Operation
- Two register groups:
  - Frame state (state, bit_cnt[2:0], byte_cnt[1:0], shift[7:0], addr accumulator): async-cleared by !RESET_N or SPI_CS high.
  - Output group (CMD_*): async-cleared by !RESET_N only. It holds its values across frames.
- Opcode classes:
  - ROW: 0x10 PROGRAM EXECUTE, 0x13 PAGE READ, 0xD8 BLOCK ERASE; 3 address bytes.
  - COL: 0x02 PROGRAM LOAD, 0x84 RANDOM PROGRAM LOAD; 2 address bytes.
  - All other opcodes: NONE.
- States:
  - ST_OPC: shift MOSI in; bit_cnt increments each rising edge. On the 8th bit, decode {shift[6:0],MOSI}. ROW/COL: latch opcode and kind internally, byte_cnt = 0, go to ST_ADDR. NONE: go to ST_SKIP.
  - ST_ADDR: shift MOSI into the accumulator MSB-first. On the 8th bit of the last address byte (byte 2 for ROW, byte 1 for COL), publish and go to ST_SKIP.
  - ST_SKIP: ignore all further bits until CS clears the frame. Data phase, dummy bytes and extra bytes are never published.
- Publish writes all outputs on the same edge:
  - CMD_OPCODE and CMD_KIND from the latched values.
  - CMD_ADDR = {zeros, accumulated bytes}; COL commands give upper 8 bits 0.
  - CMD_TGL inverted; CMD_CNT + 1, modulo 2^P_CNT_W.
- Truncated frame (CS high before the last address bit): nothing published; outputs unchanged; the next frame starts in ST_OPC with bit_cnt 0.
- A NONE opcode never changes the outputs.
- RESET_N low mid-frame: everything clears immediately and outputs return to reset values.

## Timing
- Reset values: CMD_OPCODE 0x00, CMD_KIND 0, CMD_ADDR 0, CMD_TGL 0, CMD_CNT 0.
- Publish latency: outputs are valid after the SPI_CLK rising edge that samples the last address bit.
  - ROW: edge 32 of the frame.
  - COL: edge 24.
- No SPI_CLK edge is required after CS rises; the last output update is on the sampling edge itself.
- Stability guarantee: outputs are stable for at least 24 SPI_CLK periods plus CS high time between publishes.
- Consumer CDC rule: synchronise CMD_TGL with 2 FFs in CLK200M, detect a change, then sample CMD_* (quasi-static bus). This is valid while SPI_CLK ≤ 50 MHz.
- SPI_CS deassert is asynchronous to SPI_CLK. The frame clear is applied async and released sync: the release is synchronised to SPI_CLK with a 2-FF chain on the clear-release path, and the first sampled bit of the next frame is on the rising edge after release.
  - Released to bit 0: the frame must provide ≥ 1 SPI_CLK edge of CS-low margin. This matches the device's tCSS, which is ≥ 1 clock.

## Structure
- Package ptmch_pkg:
  - Opcode constants: OPC_PRG_EXEC 8'h10, OPC_PAGE_RD 8'h13, OPC_BLK_ERS 8'hD8, OPC_PRG_LOAD 8'h02, OPC_RND_LOAD 8'h84.
  - Enum cmd_kind_t {KIND_NONE, KIND_ROW, KIND_COL}.
  - Enum cap_state_t {ST_OPC, ST_ADDR, ST_SKIP}.
  - Function addr_bytes(cmd_kind_t).
- One sub-module: ptmch_opc_dec, purely combinational, mapping opcode[7:0] to cmd_kind_t. The trigger stage reuses it.

## Test plan
- Reset, then no clocks: all outputs at reset values. A frame 0x10 0x00 0x12 0x34 then gives CMD_OPCODE 0x10, KIND 1, ADDR 0x001234, TGL 1, CNT 1 after edge 32.
- Frame 0x02 0x08 0x00 + 4 data bytes: ADDR 0x000800, KIND 2 after edge 24. Data bytes cause no further change; CNT 1.
- Frame 0x9F 0x00 0xAA (NONE), then 0x13 0x00 0x00 0x40: only one publish, ADDR 0x000040, TGL toggles once.
- Truncation: 0x10 0x00 0x12, then CS high after 4 bits of byte 3. Outputs unchanged. The next full frame 0xD8 0x01 0x02 0x03 publishes ADDR 0x010203 with correct alignment.
- 256 consecutive 0x10 frames: CNT wraps 0xFF to 0x00, and TGL ends at 0.
- RESET_N pulse at edge 20 of a ROW frame: outputs reset immediately. After release, the remainder of that frame is not published until CS cycles.

Source files
------------

// File: rtl/ptmch_pkg.sv
// rtl/ptmch_pkg.sv - shared opcode constants, kinds and states for the SPI-NAND command snoop
package ptmch_pkg;

   localparam logic [7:0] OPC_PRG_EXEC = 8'h10;
   localparam logic [7:0] OPC_PAGE_RD  = 8'h13;
   localparam logic [7:0] OPC_BLK_ERS  = 8'hD8;
   localparam logic [7:0] OPC_PRG_LOAD = 8'h02;
   localparam logic [7:0] OPC_RND_LOAD = 8'h84;

   typedef enum logic [1:0] {
      KIND_NONE = 2'd0,
      KIND_ROW  = 2'd1,
      KIND_COL  = 2'd2
   } cmd_kind_t;

   typedef enum logic [1:0] {
      ST_OPC  = 2'd0,
      ST_ADDR = 2'd1,
      ST_SKIP = 2'd2
   } cap_state_t;

   // Number of address bytes that follow the opcode for each command kind.
   function automatic logic [1:0] addr_bytes(input cmd_kind_t kind);
      case (kind)
         KIND_ROW: addr_bytes = 2'd3;
         KIND_COL: addr_bytes = 2'd2;
         default:  addr_bytes = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/ptmch_opc_dec.sv
// rtl/ptmch_opc_dec.sv - combinational opcode classifier shared with the trigger stage
module ptmch_opc_dec
   import ptmch_pkg::*;
(
   input  logic [7:0] opcode_i,
   output cmd_kind_t  kind_o
);

   always_comb begin
      kind_o = KIND_NONE;
      case (opcode_i)
         OPC_PRG_EXEC, OPC_PAGE_RD, OPC_BLK_ERS: kind_o = KIND_ROW;
         OPC_PRG_LOAD, OPC_RND_LOAD:             kind_o = KIND_COL;
         default:                                kind_o = KIND_NONE;
      endcase
   end

endmodule

// File: rtl/ptmch_cmd_cap.sv
// rtl/ptmch_cmd_cap.sv - SPI_CLK-domain opcode/address capture with toggle-strobe publish
module ptmch_cmd_cap
   import ptmch_pkg::*;
#(
   parameter int P_ADDR_W = 24,
   parameter int P_CNT_W  = 8
) (
   input  logic                SPI_CLK,
   input  logic                RESET_N,
   input  logic                SPI_CS,
   input  logic                SPI_MOSI,
   output logic [7:0]          CMD_OPCODE,
   output logic [1:0]          CMD_KIND,
   output logic [P_ADDR_W-1:0] CMD_ADDR,
   output logic                CMD_TGL,
   output logic [P_CNT_W-1:0]  CMD_CNT
);

   // A reset taken while CS is low locks out the rest of that frame until CS rises.
   logic lock_q;
   always_ff @(negedge RESET_N or posedge SPI_CS) begin
      if (SPI_CS) lock_q <= 1'b0;
      else        lock_q <= 1'b1;
   end

   // Frame clear asserts asynchronously; release passes a posedge then a negedge
   // flop so it lands half a period before the rising edge that samples bit 0.
   logic chain_rst_n;
   logic sync0_q;
   logic sync1_q;
   assign chain_rst_n = RESET_N & ~SPI_CS & ~lock_q;

   always_ff @(posedge SPI_CLK or negedge chain_rst_n) begin
      if (!chain_rst_n) sync0_q <= 1'b0;
      else              sync0_q <= 1'b1;
   end

   always_ff @(negedge SPI_CLK or negedge chain_rst_n) begin
      if (!chain_rst_n) sync1_q <= 1'b0;
      else              sync1_q <= sync0_q;
   end

   logic frame_rst_n;
   assign frame_rst_n = sync1_q;

   cap_state_t  state_q,    state_d;
   logic [2:0]  bit_cnt_q,  bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shift_q,    shift_d;
   logic [23:0] acc_q,      acc_d;
   logic [7:0]  opc_q,      opc_d;
   cmd_kind_t   kind_q,     kind_d;
   logic        publish;

   logic [7:0]  bits_in;
   cmd_kind_t   dec_kind;
   assign bits_in = {shift_q[6:0], SPI_MOSI};

   ptmch_opc_dec u_opc_dec (
      .opcode_i (bits_in),
      .kind_o   (dec_kind)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_cnt_d = byte_cnt_q;
      shift_d    = bits_in;
      acc_d      = acc_q;
      opc_d      = opc_q;
      kind_d     = kind_q;
      publish    = 1'b0;
      case (state_q)
         ST_OPC: begin
            if (bit_cnt_q == 3'd7) begin
               if (dec_kind != KIND_NONE) begin
                  opc_d      = bits_in;
                  kind_d     = dec_kind;
                  byte_cnt_d = 2'd0;
                  acc_d      = 24'd0;
                  state_d    = ST_ADDR;
               end else begin
                  state_d = ST_SKIP;
               end
            end
         end
         ST_ADDR: begin
            acc_d = {acc_q[22:0], SPI_MOSI};
            if (bit_cnt_q == 3'd7) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == addr_bytes(kind_q) - 2'd1) begin
                  publish = 1'b1;
                  state_d = ST_SKIP;
               end
            end
         end
         ST_SKIP: begin
            bit_cnt_d = bit_cnt_q;
            shift_d   = shift_q;
         end
         default: state_d = ST_SKIP;
      endcase
   end

   always_ff @(posedge SPI_CLK or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         state_q    <= ST_OPC;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 2'd0;
         shift_q    <= 8'd0;
         acc_q      <= 24'd0;
         opc_q      <= 8'd0;
         kind_q     <= KIND_NONE;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         opc_q      <= opc_d;
         kind_q     <= kind_d;
      end
   end

   // Published group survives CS; only RESET_N clears it.
   logic [7:0]          cmd_opcode_q;
   cmd_kind_t           cmd_kind_q;
   logic [P_ADDR_W-1:0] cmd_addr_q;
   logic                cmd_tgl_q;
   logic [P_CNT_W-1:0]  cmd_cnt_q;

   always_ff @(posedge SPI_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cmd_opcode_q <= 8'd0;
         cmd_kind_q   <= KIND_NONE;
         cmd_addr_q   <= '0;
         cmd_tgl_q    <= 1'b0;
         cmd_cnt_q    <= '0;
      end else if (publish) begin
         cmd_opcode_q <= opc_q;
         cmd_kind_q   <= kind_q;
         cmd_addr_q   <= P_ADDR_W'(acc_d);
         cmd_tgl_q    <= ~cmd_tgl_q;
         cmd_cnt_q    <= cmd_cnt_q + P_CNT_W'(1);
      end
   end

   assign CMD_OPCODE = cmd_opcode_q;
   assign CMD_KIND   = cmd_kind_q;
   assign CMD_ADDR   = cmd_addr_q;
   assign CMD_TGL    = cmd_tgl_q;
   assign CMD_CNT    = cmd_cnt_q;

endmodule

// File: tb/tb_ptmch_cmd_cap.sv
// tb/tb_ptmch_cmd_cap.sv - directed vector bench for ptmch_cmd_cap
module tb_ptmch_cmd_cap;

   logic        SPI_CLK  = 1'b0;
   logic        RESET_N  = 1'b1;
   logic        SPI_CS   = 1'b1;
   logic        SPI_MOSI = 1'b0;
   logic [7:0]  CMD_OPCODE;
   logic [1:0]  CMD_KIND;
   logic [23:0] CMD_ADDR;
   logic        CMD_TGL;
   logic [7:0]  CMD_CNT;

   int checks = 0;
   int errors = 0;

   ptmch_cmd_cap #(.P_ADDR_W(24), .P_CNT_W(8)) dut (
      .SPI_CLK    (SPI_CLK),
      .RESET_N    (RESET_N),
      .SPI_CS     (SPI_CS),
      .SPI_MOSI   (SPI_MOSI),
      .CMD_OPCODE (CMD_OPCODE),
      .CMD_KIND   (CMD_KIND),
      .CMD_ADDR   (CMD_ADDR),
      .CMD_TGL    (CMD_TGL),
      .CMD_CNT    (CMD_CNT)
   );

   typedef struct {
      bit          rst;
      logic [63:0] data;
      int          nbits;
      logic [7:0]  opc;
      logic [1:0]  kind;
      logic [23:0] addr;
      logic        tgl;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] opc, input logic [1:0] kind,
                            input logic [23:0] addr, input logic tgl, input logic [7:0] cnt);
      check({tag, " opcode"}, 32'(CMD_OPCODE), 32'(opc));
      check({tag, " kind"},   32'(CMD_KIND),   32'(kind));
      check({tag, " addr"},   32'(CMD_ADDR),   32'(addr));
      check({tag, " tgl"},    32'(CMD_TGL),    32'(tgl));
      check({tag, " cnt"},    32'(CMD_CNT),    32'(cnt));
   endtask

   task automatic bit_out(input logic b);
      SPI_MOSI = b;
      #5 SPI_CLK = 1'b1;
      #5 SPI_CLK = 1'b0;
   endtask

   task automatic send_bits(input logic [63:0] data, input int n);
      for (int i = 0; i < n; i++) bit_out(data[63-i]);
   endtask

   task automatic cs_low();
      SPI_CS = 1'b0;
      #5;
      bit_out(1'b0);
   endtask

   task automatic cs_high();
      #5 SPI_CS = 1'b1;
      #10;
   endtask

   task automatic do_reset();
      #2 RESET_N = 1'b0;
      #5 RESET_N = 1'b1;
      #5;
   endtask

   initial begin
      vecs[0] = '{1'b1, 64'h1000_1234_0000_0000, 32, 8'h10, 2'd1, 24'h001234, 1'b1, 8'd1};
      vecs[1] = '{1'b1, 64'h0208_00AA_55FF_0000, 56, 8'h02, 2'd2, 24'h000800, 1'b1, 8'd1};
      vecs[2] = '{1'b0, 64'h9F00_AA00_0000_0000, 24, 8'h02, 2'd2, 24'h000800, 1'b1, 8'd1};
      vecs[3] = '{1'b0, 64'h1300_0040_0000_0000, 32, 8'h13, 2'd1, 24'h000040, 1'b0, 8'd2};
      vecs[4] = '{1'b0, 64'h1000_1234_0000_0000, 28, 8'h13, 2'd1, 24'h000040, 1'b0, 8'd2};
      vecs[5] = '{1'b0, 64'hD801_0203_0000_0000, 32, 8'hD8, 2'd1, 24'h010203, 1'b1, 8'd3};
      vecs[6] = '{1'b0, 64'h84AB_CD00_0000_0000, 24, 8'h84, 2'd2, 24'h00ABCD, 1'b0, 8'd4};
      vecs[7] = '{1'b0, 64'h84AB_CD00_0000_0000, 23, 8'h84, 2'd2, 24'h00ABCD, 1'b0, 8'd4};
      vecs[8] = '{1'b0, 64'h10FF_FFFF_0000_0000, 32, 8'h10, 2'd1, 24'hFFFFFF, 1'b1, 8'd5};

      #1;
      do_reset();
      check_out("reset", 8'h00, 2'd0, 24'h0, 1'b0, 8'd0);

      // ROW publish lands exactly on edge 32
      cs_low();
      send_bits(64'h1000_1234_0000_0000, 31);
      check("row edge31 cnt", 32'(CMD_CNT), 32'd0);
      bit_out(1'b0);
      check_out("row edge32", 8'h10, 2'd1, 24'h001234, 1'b1, 8'd1);
      cs_high();

      // COL publish lands exactly on edge 24
      cs_low();
      send_bits(64'h0208_0000_0000_0000, 23);
      check("col edge23 cnt", 32'(CMD_CNT), 32'd1);
      bit_out(1'b0);
      check_out("col edge24", 8'h02, 2'd2, 24'h000800, 1'b0, 8'd2);
      cs_high();

      for (int v = 0; v < 9; v++) begin
         if (vecs[v].rst) do_reset();
         cs_low();
         send_bits(vecs[v].data, vecs[v].nbits);
         check_out($sformatf("vec%0d", v), vecs[v].opc, vecs[v].kind, vecs[v].addr,
                   vecs[v].tgl, vecs[v].cnt);
         cs_high();
         check($sformatf("vec%0d cnt after cs", v), 32'(CMD_CNT), 32'(vecs[v].cnt));
      end

      // 256 ROW frames wrap the counter back to zero
      do_reset();
      for (int i = 0; i < 256; i++) begin
         cs_low();
         send_bits(64'h1000_0000_0000_0000, 32);
         cs_high();
         if (i == 254) begin
            check("wrap cnt 255", 32'(CMD_CNT), 32'hFF);
            check("wrap tgl 255", 32'(CMD_TGL), 32'd1);
         end
      end
      check("wrap cnt", 32'(CMD_CNT), 32'd0);
      check("wrap tgl", 32'(CMD_TGL), 32'd0);
      check("wrap opcode", 32'(CMD_OPCODE), 32'h10);

      // RESET_N mid-frame: immediate clear, and the frame tail stays dead until CS cycles
      cs_low();
      send_bits(64'h1300_0040_0000_0000, 32);
      cs_high();
      check("pre-rst cnt", 32'(CMD_CNT), 32'd1);
      cs_low();
      send_bits(64'h1000_1234_0000_0000, 20);
      #2 RESET_N = 1'b0;
      #2;
      check_out("midrst", 8'h00, 2'd0, 24'h0, 1'b0, 8'd0);
      RESET_N = 1'b1;
      #2;
      send_bits({1'b0, 32'h1300_0040, 31'd0}, 33);
      check_out("post-rst tail", 8'h00, 2'd0, 24'h0, 1'b0, 8'd0);
      cs_high();
      cs_low();
      send_bits(64'hD801_0203_0000_0000, 32);
      check_out("post-rst frame", 8'hD8, 2'd1, 24'h010203, 1'b1, 8'd1);
      cs_high();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
